// File: rtl/iir_sample_feeder.sv
// Feeds a biquad IIR core one sample at a time from a small input FIFO and
// captures its result into a ready/valid output register, with a stall timeout.
module iir_sample_feeder #(
  parameter int DW      = 18,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] iir_din,
  output logic          iir_din_valid,
  input  logic [DW-1:0] iir_dout,
  input  logic          iir_dout_valid,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          err
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [TCW-1:0] TC_LIMIT   = TCW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [TCW-1:0] tc;
  logic          push;
  logic          pop;

  assign s_ready       = (count != FULL_LEVEL);
  assign push          = s_valid && s_ready;
  // A new sample is only issued once the previous result has been taken.
  assign pop           = (state == IDLE) && (count != '0) && !m_valid;
  assign level         = count;
  assign iir_din_valid = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Any dout_valid outside WAIT means the filter and this feeder disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      iir_din <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      err     <= 1'b0;
      tc      <= '0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (iir_dout_valid) begin
            err <= 1'b1;
          end
          if (pop) begin
            iir_din <= mem[rd_ptr];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (iir_dout_valid) begin
            err <= 1'b1;
          end
          tc    <= TCW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (iir_dout_valid) begin
            m_data  <= iir_dout;
            m_valid <= 1'b1;
            state   <= IDLE;
          end else if (tc == TC_LIMIT) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tc <= tc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Scoreboard bench for iir_sample_feeder: a behavioural filter model answers
// each issue, and a monitor compares every accepted result against the queue.
module tb_iir_sample_feeder;

  localparam int DW      = 18;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 15;
  localparam logic [DW-1:0] SPUR_VAL = 18'h2AAAA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] iir_din;
  logic          iir_din_valid;
  logic [DW-1:0] iir_dout;
  logic          iir_dout_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [AW:0]   level;
  logic          err;

  logic [DW-1:0] model_dout;
  logic          model_dv;
  logic          spur_dv;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int issue_cnt = 0;
  bit hang = 1'b0;
  bit model_busy = 1'b0;
  bit mr_random = 1'b0;
  bit mr_fixed = 1'b1;

  logic [DW-1:0] sample_q[$];
  logic [DW-1:0] res_q[$];

  assign iir_dout_valid = model_dv | spur_dv;
  assign iir_dout       = spur_dv ? SPUR_VAL : model_dout;

  iir_sample_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .iir_din(iir_din), .iir_din_valid(iir_din_valid),
    .iir_dout(iir_dout), .iir_dout_valid(iir_dout_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  always @(posedge clk) begin
    #2;
    m_ready = mr_random ? 1'($urandom_range(0, 1)) : mr_fixed;
  end

  // Filter response: a fixed affine map of the sample, wrapped to DW bits.
  function automatic logic [DW-1:0] filt(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x)) * 5 - 3;
    return v[DW-1:0];
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_issue(output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (iir_din_valid) begin ok = 1'b1; c = cyc; break; end
    end
    check_output("issue_seen", int'(ok), 1);
  endtask

  task automatic wait_mvalid(output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid) begin ok = 1'b1; c = cyc; break; end
    end
    check_output("m_valid_seen", int'(ok), 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (sample_q.size() == 0 && res_q.size() == 0 && !model_busy &&
          level == 0 && !m_valid) begin
        done = 1'b1;
        break;
      end
    end
    check_output("drain", int'(done), 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sample_q.delete();
    res_q.delete();
  endtask

  // Accepted input samples, in arrival order.
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) sample_q.push_back(s_data);
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (res_q.size() == 0) check_output("unexpected_result", int'($signed(m_data)), 0);
      else check_output("result", int'($signed(m_data)), int'($signed(res_q.pop_front())));
    end
  end

  // Filter model: samples din at +1 and +4, answers in the 6th cycle after issue.
  initial begin
    logic [DW-1:0] exp_s;
    bit h;
    int rc;
    model_dv   = 1'b0;
    model_dout = '0;
    forever begin
      @(negedge clk);
      if (!rst && iir_din_valid) begin
        model_busy = 1'b1;
        issue_cnt++;
        h  = hang;
        rc = rst_cnt;
        if (sample_q.size() == 0) begin
          check_output("issue_without_sample", 1, 0);
          exp_s = iir_din;
        end else begin
          exp_s = sample_q.pop_front();
        end
        check_output("issue_order", int'($signed(iir_din)), int'($signed(exp_s)));
        @(negedge clk);
        if (rc == rst_cnt) check_output("din_hold_t1", int'($signed(iir_din)), int'($signed(exp_s)));
        repeat (3) @(negedge clk);
        if (rc == rst_cnt) check_output("din_hold_t4", int'($signed(iir_din)), int'($signed(exp_s)));
        if (!h && rc == rst_cnt) begin
          @(posedge clk);
          @(posedge clk); #1;
          model_dout = filt(exp_s);
          model_dv   = 1'b1;
          res_q.push_back(filt(exp_s));
          @(posedge clk); #1;
          model_dv = 1'b0;
        end else begin
          repeat (11) @(negedge clk);
        end
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, i0;
    bit ok;
    s_valid = 1'b0;
    s_data  = '0;
    spur_dv = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_level", int'(level), 0);
    check_output("rst_s_ready", int'(s_ready), 1);
    check_output("rst_iir_din", int'(iir_din), 0);
    check_output("rst_din_valid", int'(iir_din_valid), 0);
    check_output("rst_m_valid", int'(m_valid), 0);
    check_output("rst_m_data", int'(m_data), 0);
    check_output("rst_err", int'(err), 0);

    // Reset while the filter is mid-computation.
    @(posedge clk); #1;
    hang = 1'b1;
    apply_stimulus(DW'(100));
    wait_issue(c0);
    @(posedge clk); #1;
    hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midwait_level", int'(level), 0);
    check_output("midwait_iir_din", int'(iir_din), 0);
    check_output("midwait_din_valid", int'(iir_din_valid), 0);
    check_output("midwait_m_valid", int'(m_valid), 0);
    check_output("midwait_s_ready", int'(s_ready), 1);
    check_output("midwait_err", int'(err), 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!model_busy) begin ok = 1'b1; break; end
    end
    check_output("model_idle", int'(ok), 1);
    sample_q.delete();

    // Single sample latency from issue to result.
    @(posedge clk); #1;
    apply_stimulus(DW'(1000));
    wait_issue(c0);
    wait_mvalid(c1);
    check_output("issue_to_result", c1 - c0, 7);
    drain();

    // Hold a result unconsumed, fill the FIFO, push while full, then release.
    @(posedge clk); #1;
    mr_fixed = 1'b0;
    apply_stimulus(DW'(777));
    wait_mvalid(c1);
    @(posedge clk); #1;
    i0 = issue_cnt;
    for (int i = 0; i < DEPTH; i++) apply_stimulus(DW'(i - 5));
    @(negedge clk);
    check_output("full_level", int'(level), DEPTH);
    check_output("full_s_ready", int'(s_ready), 0);
    check_output("no_issue_while_m_valid", issue_cnt, i0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check_output("push_when_full_level", int'(level), DEPTH);
    @(posedge clk); #1;
    mr_fixed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("no_issue_1_after_ready", int'(iir_din_valid), 0);
    @(negedge clk);
    check_output("issue_2_after_ready", int'(iir_din_valid), 1);
    check_output("first_pop_level", int'(level), DEPTH - 1);
    check_output("first_pop_s_ready", int'(s_ready), 1);
    mr_random = 1'b1;
    drain();

    // Randomized traffic with random downstream backpressure.
    @(posedge clk); #1;
    for (int i = 0; i < 250; i++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      s_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain();
    check_output("err_after_random", int'(err), 0);

    // Filter never answers: timeout sets err and the next sample still flows.
    mr_random = 1'b0;
    mr_fixed  = 1'b1;
    @(posedge clk); #1;
    hang = 1'b1;
    apply_stimulus(DW'(321));
    wait_issue(c0);
    @(posedge clk); #1;
    hang = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_output("err_before_timeout", int'(err), 0);
    @(negedge clk);
    check_output("err_at_timeout", int'(err), 1);
    check_output("timeout_idle", int'(iir_din_valid), 0);
    check_output("timeout_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    apply_stimulus(-DW'(77));
    drain();
    check_output("err_sticky", int'(err), 1);

    // Spurious dout_valid while idle with a result pending.
    apply_reset();
    @(negedge clk);
    check_output("err_cleared_by_rst", int'(err), 0);
    @(posedge clk); #1;
    mr_fixed = 1'b0;
    apply_stimulus(DW'(555));
    wait_mvalid(c1);
    @(posedge clk); #1;
    spur_dv = 1'b1;
    @(posedge clk); #1;
    spur_dv = 1'b0;
    @(negedge clk);
    check_output("spurious_err", int'(err), 1);
    check_output("spurious_m_valid", int'(m_valid), 1);
    check_output("spurious_m_data", int'($signed(m_data)), int'($signed(filt(DW'(555)))));
    @(posedge clk); #1;
    mr_fixed = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
